// File: rtl/seg7_scan_ctrl_if.sv
// CPU IO-bus write port for the seven-segment controller: decoded select, write strobe,
// register select and write data.
interface seg7_scan_ctrl_if;
  logic        SegCtrl;
  logic        ioWrite;
  logic        reg_sel;
  logic [31:0] write_data;

  modport master (output SegCtrl, ioWrite, reg_sel, write_data);
  modport slave  (input  SegCtrl, ioWrite, reg_sel, write_data);
endinterface

// File: rtl/seg7_scan_ctrl.sv
// 8-digit multiplexed seven-segment controller; optional LEADING_ZERO_BLANK_EN blanks leading zeros.
// Outputs registered with 1-cycle latency from index/registers; register writes always accepted, no backpressure.
module seg7_scan_ctrl #(
  parameter int CLK_HZ       = 23000000,
  parameter int SCAN_HZ      = 1000,
  parameter int BLANK_CYCLES = 16
) (
  input  logic             clock,
  input  logic             reset,
  seg7_scan_ctrl_if.slave  bus,
  output logic [7:0]       seg_out,
  output logic [7:0]       an_out,
  output logic [2:0]       cur_digit
);

  localparam int DWELL = CLK_HZ / SCAN_HZ;
  localparam int CW    = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] BLANK_END  = CW'(BLANK_CYCLES);

  logic [31:0]   data_reg;
  logic [7:0]    mask;
  logic [7:0]    dp;
  logic [CW-1:0] dwell_cnt;
  logic [2:0]    index;
  logic [3:0]    nibble;
  logic          digit_on;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;  4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;  4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;  4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;  4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_reg <= '0;
      mask     <= 8'hFF;
      dp       <= 8'h00;
    end else if (bus.SegCtrl && bus.ioWrite) begin
      if (bus.reg_sel) begin
        mask <= bus.write_data[7:0];
        dp   <= bus.write_data[15:8];
      end else begin
        data_reg <= bus.write_data;
      end
    end
  end

  // Scan timing free-runs; register writes never restart it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      dwell_cnt <= '0;
      index     <= 3'd0;
    end else if (dwell_cnt == DWELL_LAST) begin
      dwell_cnt <= '0;
      index     <= index + 3'd1;
    end else begin
      dwell_cnt <= dwell_cnt + 1'b1;
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic [7:0] upper_zero;
  logic       zero_run;

  // upper_zero[i] is set when nibbles i..7 are all zero.
  always_comb begin
    upper_zero = '0;
    zero_run   = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      zero_run      = zero_run && (data_reg[4*i +: 4] == 4'd0);
      upper_zero[i] = zero_run;
    end
  end
`endif

  always_comb begin
    nibble   = data_reg[{index, 2'b00} +: 4];
    digit_on = mask[index];
`ifdef LEADING_ZERO_BLANK_EN
    if (index != 3'd0 && !dp[index] && upper_zero[index])
      digit_on = 1'b0;
`endif
  end

  // Single decoded anode per cycle keeps at most one digit lit at any time.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      seg_out   <= 8'hFF;
      an_out    <= 8'hFF;
      cur_digit <= 3'd0;
    end else begin
      cur_digit <= index;
      if (dwell_cnt < BLANK_END || !digit_on) begin
        seg_out <= 8'hFF;
        an_out  <= 8'hFF;
      end else begin
        seg_out <= {~dp[index], hex7(nibble)};
        an_out  <= ~(8'h01 << index);
      end
    end
  end

endmodule

// File: doc/seg7_scan_ctrl.md
Name: seg7_scan_ctrl

Overview:
Memory-mapped 8-digit seven-segment display controller on the CPU IO bus, downstream of the MemOrIO address decoder alongside the led and switch blocks.
- Consumes decoded select, ioWrite and 32-bit write data from sw instructions.
- Holds a data register (8 hex nibbles) and a control register (digit-enable mask, decimal points).
- Time-multiplexes the digits onto shared active-low segment and anode lines, with an anti-ghosting blank window.

Parameters:
CLK_HZ, 23000000, frequency of clock in Hz.
SCAN_HZ, 1000, per-digit dwell rate; dwell length DWELL = CLK_HZ/SCAN_HZ cycles.
BLANK_CYCLES, 16, cycles at the start of each dwell with all anodes off; must be < DWELL.

Ports:
clock  in  1  system clock (CPU clock domain)
reset  in  1  asynchronous, active-low reset
SegCtrl  in  1  address decode select for this block
ioWrite  in  1  IO write strobe
reg_sel  in  1  0 = data register, 1 = control register
write_data  in  32  bus write data
seg_out  out  8  [6:0] = g..a, [7] = dp; active-low
an_out  out  8  digit anodes, bit i = digit i; active-low
cur_digit  out  3  index of digit currently driven (debug)

Behaviour:
- Reset (reset low, async), all registered:
  - data_reg = 0; mask = 8'hFF; dp = 8'h00.
  - Dwell counter = 0; index = 0; cur_digit = 0.
  - an_out = 8'hFF; seg_out = 8'hFF.
- Register write: on a rising clock with SegCtrl && ioWrite.
  - reg_sel = 0: data_reg <= write_data.
  - reg_sel = 1: mask <= write_data[7:0]; dp <= write_data[15:8]; bits [31:16] ignored.
  - Writes without SegCtrl, or SegCtrl without ioWrite: no effect.
- Dwell counter:
  - Counts 0..DWELL-1.
  - At DWELL-1: wraps to 0 and index increments (7 wraps to 0).
  - Runs continuously, unaffected by writes.
- Outputs are registered every cycle from the current index and current registers (1-cycle latency):
  - While counter < BLANK_CYCLES: an_out = 8'hFF, seg_out = 8'hFF.
  - Otherwise, if mask[index] = 1: an_out = ~(1 << index); seg_out[6:0] = hex decode of data_reg[4*index+3 : 4*index]; seg_out[7] = ~dp[index].
  - Otherwise (digit disabled): an_out = 8'hFF, seg_out = 8'hFF.
  - cur_digit = index, registered alongside the other outputs.
- Hex decode (g..a, active-low), full 16-entry table:
  - 0:40, 1:79, 2:24, 3:30, 4:19, 5:12, 6:02, 7:78
  - 8:00, 9:10, A:08, b:03, C:46, d:21, E:06, F:0E
- Write during a dwell: new digit value appears on seg_out the cycle after the write edge. No restart of scan.
- Simultaneous write and dwell wrap: both take effect. Next output uses new index and new data.
- At most one anode low in any cycle, including across reset release and register writes.
- Reset asserted mid-scan: outputs go to 8'hFF immediately (async). Scan restarts at digit 0, counter 0 after release.

Optional Feature:
LEADING_ZERO_BLANK_EN
- Defined: a digit also blanks (an_out bit high, seg_out 8'hFF) when its nibble and all higher-index nibbles are 0.
  - Digit 0 never blanks by this rule.
  - dp[i] = 1 overrides the blank for digit i.
  - Mask rule still applies.
- Undefined: all enabled digits display, zeros included.

Test Plan:
Simulation uses CLK_HZ=100, SCAN_HZ=10 (DWELL=10), BLANK_CYCLES=2.
- Reset, then release -> an_out = FF and seg_out = FF during the blank window; cycle 3 of the dwell an_out = FE, seg_out = C0 (digit 0 = "0", dp off).
- Write data 32'h89ABCDEF (reg_sel=0) -> over one 80-cycle scan:
  - digit 0: seg_out[6:0] = 0E with an_out = FE;
  - digit 7: seg_out[6:0] = 00 with an_out = 7F;
  - cur_digit 0..7 in order, wraps to 0.
- Write control 32'h0000_0105 (mask = 05, dp = 01) -> only an_out = FE and FB ever low; digit 0 seg_out[7] = 0; digits 1 and 3-7 output FF.
- Write data 32'h00000001 mid-dwell of digit 0 -> seg_out changes C0 -> F9 exactly one cycle after the write edge; an_out unchanged.
- Assert reset at counter = 5, index = 3 -> outputs FF in the same cycle; after release digit 0 shown first, registers back to defaults.
- With LEADING_ZERO_BLANK_EN, data 32'h00000120, mask FF -> digits 3-7 blank, digits 0-2 show 0/2/1; with dp = 08, digit 3 shows "0." (seg_out = 40).
